// File: rtl/t_readback.sv
// Streams T(0, i) results out of BRAM: issues one read per index, absorbs the fixed read
// latency, and buffers returns in a credit-managed skid FIFO behind a valid/ready port.
module t_readback #(
   parameter int unsigned BIT_WIDTH    = 32,
   parameter int unsigned I            = 160,
   parameter int unsigned NU_VALUES    = 3,
   parameter int unsigned BRAM_LATENCY = 2,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   start_in,
   output logic [$clog2(I)-1:0]   bram_addr,
   output logic                   bram_rd_en,
   input  logic [BIT_WIDTH-1:0]   bram_data_0,
   input  logic [BIT_WIDTH-1:0]   bram_data_1,
   input  logic [BIT_WIDTH-1:0]   bram_data_2,
   output logic [BIT_WIDTH-1:0]   out_data_0,
   output logic [BIT_WIDTH-1:0]   out_data_1,
   output logic [BIT_WIDTH-1:0]   out_data_2,
   output logic [$clog2(I)-1:0]   out_index,
   output logic                   out_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   busy,
   output logic                   done
);

   localparam int unsigned AW = $clog2(I);
   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [AW-1:0] LastAddr = AW'(I - 1);

   if (NU_VALUES != 3 || FIFO_DEPTH < BRAM_LATENCY + 1) begin : g_cfg_err
      $error("t_readback: unsupported parameter set");
   end

   typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

   state_e                 state_q, state_d;
   logic                   rd_en_q, rd_en_d;
   logic [AW-1:0]          addr_q, addr_d;
   logic [BRAM_LATENCY-1:0] pipe_v_q, pipe_v_d;
   logic [AW-1:0]          pipe_addr_q [BRAM_LATENCY];
   logic [CW-1:0]          count_q, count_d;
   logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
   logic [BIT_WIDTH-1:0]   mem0_q [FIFO_DEPTH];
   logic [BIT_WIDTH-1:0]   mem1_q [FIFO_DEPTH];
   logic [BIT_WIDTH-1:0]   mem2_q [FIFO_DEPTH];
   logic [AW-1:0]          mem_idx_q [FIFO_DEPTH];
   logic                   push, pop;
   int unsigned            occ;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign push = pipe_v_q[BRAM_LATENCY-1];
   assign pop  = out_valid && out_ready;

   always_comb begin : datapath_next
      pipe_v_d    = '0;
      pipe_v_d[0] = rd_en_q;
      for (int k = 1; k < BRAM_LATENCY; k++) pipe_v_d[k] = pipe_v_q[k-1];
      count_d = count_q;
      if (push && !pop) count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin : state_reg
      if (rst_in) begin
         state_q  <= StIdle;
         rd_en_q  <= 1'b0;
         addr_q   <= '0;
         pipe_v_q <= '0;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         rd_en_q  <= rd_en_d;
         addr_q   <= addr_d;
         pipe_v_q <= pipe_v_d;
         count_q  <= count_d;
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
   end

   // Storage only; validity is carried by pipe_v_q and count_q, which do reset.
   always_ff @(posedge clk_in) begin : storage
      pipe_addr_q[0] <= addr_q;
      for (int k = 1; k < BRAM_LATENCY; k++) pipe_addr_q[k] <= pipe_addr_q[k-1];
      if (push) begin
         mem0_q[wr_ptr_q]    <= bram_data_0;
         mem1_q[wr_ptr_q]    <= bram_data_1;
         mem2_q[wr_ptr_q]    <= bram_data_2;
         mem_idx_q[wr_ptr_q] <= pipe_addr_q[BRAM_LATENCY-1];
      end
   end

   always_comb begin : next_state
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start_in) state_d = StRead;
         StRead:  if (rd_en_q && addr_q == LastAddr) state_d = StDrain;
         StDrain: if (pipe_v_d == '0 && count_d == '0) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin : fsm_outputs
      // Credit check on next-cycle occupancy, since the strobe itself is registered.
      occ = 32'(count_d);
      for (int k = 0; k < BRAM_LATENCY; k++) occ = occ + 32'(pipe_v_d[k]);
      rd_en_d = (state_d == StRead) && (occ < FIFO_DEPTH);
      addr_d  = addr_q;
      if (state_q == StDone) addr_d = '0;
      else if (rd_en_q && addr_q != LastAddr) addr_d = addr_q + 1'b1;
      busy = (state_q != StIdle);
      done = (state_q == StDone);
   end

   assign bram_rd_en = rd_en_q;
   assign bram_addr  = addr_q;
   assign out_valid  = (count_q != '0);
   assign out_data_0 = out_valid ? mem0_q[rd_ptr_q] : '0;
   assign out_data_1 = out_valid ? mem1_q[rd_ptr_q] : '0;
   assign out_data_2 = out_valid ? mem2_q[rd_ptr_q] : '0;
   assign out_index  = out_valid ? mem_idx_q[rd_ptr_q] : '0;
   assign out_last   = out_valid && (mem_idx_q[rd_ptr_q] == LastAddr);

endmodule

// File: doc/t_readback.md
# t_readback

Streams the T(0, i) results back out of BRAM after the T stage has written all I entries. A `start_in` pulse makes it issue one BRAM read per entry and absorb the fixed BRAM read latency. It delivers the three NU columns per index on a valid/ready output stream to the downstream stage. A small credit-managed skid FIFO makes backpressure lossless without stalling the BRAM pipeline.

## Interface
Parameters:
- BIT_WIDTH, 32, width of each T value
- I, 160, number of indices stored in BRAM
- NU_VALUES, 3, columns per index; the block is fixed at 3 data ports
- BRAM_LATENCY, 2, cycles from `bram_rd_en`/`bram_addr` to valid `bram_data_*`
- FIFO_DEPTH, 4, skid FIFO entries; must be ≥ BRAM_LATENCY+1

Ports:
- clk_in  in  1  single clock
- rst_in  in  1  reset, asynchronous, active-high
- start_in  in  1  one-cycle pulse that begins a readback pass
- bram_addr  out  $clog2(I)  read address
- bram_rd_en  out  1  read strobe
- bram_data_0/1/2  in  BIT_WIDTH  BRAM read data, valid BRAM_LATENCY cycles after the strobe
- out_data_0/1/2  out  BIT_WIDTH  T values for `out_index`
- out_index  out  $clog2(I)  index of the current word
- out_last  out  1  high with the word for index I-1
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accept
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after the last word is accepted

## Operation
- States:
  - IDLE: `start_in`=1 → READ; otherwise stay.
  - READ: issues reads; after the read of address I-1 is issued → DRAIN.
  - DRAIN: waits for in-flight reads and an empty FIFO.
  - DONE: one cycle, `done`=1, → IDLE.
- `start_in` is ignored in every state except IDLE.
- Read issue rule, in READ: `bram_rd_en`=1 iff (fifo_count + inflight) < FIFO_DEPTH. `bram_addr` increments 0..I-1 after each issued read and never wraps within a pass.
- In-flight tracking: a BRAM_LATENCY-deep shift register carries a valid bit plus address. When it emerges, data and index are pushed into the FIFO. Credits guarantee the FIFO never overflows, so no push is ever dropped.
- Output: the FIFO head drives `out_data_*`, `out_index` and `out_last`. A pop occurs on `out_valid && out_ready`.
- Simultaneous push and pop in one cycle: count is unchanged and both operations happen.
- DRAIN → DONE when inflight=0 and the FIFO is empty, i.e. after the pop of index I-1.
- `busy`=1 in READ and DRAIN.
- Data is passed through unmodified. No arithmetic is applied to T values.
- Reset, including mid-pass: state → IDLE. FIFO count, in-flight valid bits and address counter all clear. Returns already in flight are discarded.

## Timing
- Reset values: every output is 0.
- `start_in` is sampled at edge 0. READ begins in cycle 1 with `bram_rd_en`=1 and `bram_addr`=0; both outputs are registered.
- Data for address 0 is present in cycle 1+BRAM_LATENCY, is pushed at that cycle's edge, and gives `out_valid` in cycle 2+BRAM_LATENCY (cycle 4 at defaults).
- With `out_ready` held high, throughput is 1 word/cycle:
  - words for indices 0..I-1 appear in cycles 4..163;
  - `out_last` is high in cycle 163;
  - `done` pulses in cycle 164;
  - `busy` drops in cycle 165.
- `out_valid` never drops while the FIFO is non-empty. `out_data_*`, `out_index` and `out_last` stay stable while `out_valid`=1 and `out_ready`=0.
- Maximum outstanding reads plus FIFO occupancy is FIFO_DEPTH.

## Test plan
- Full pass, ready held high; BRAM model returns data_k = {addr, k}. Required: 160 words with indices 0..159 in order on cycles 4..163, data matching the model, `out_last` only on index 159, `done` exactly once at cycle 164.
- Backpressure: drop `out_ready` for 10 cycles at cycle 20. Required: `bram_rd_en` stops within FIFO_DEPTH cycles, the FIFO reaches 4 entries without overflow, and there are no missing or duplicate indices after release.
- Random `out_ready` at 30% duty over a full pass. Required: output sequence identical to the full-pass case and held data stable while stalled.
- Pulse `start_in` in READ and in DRAIN. Required: no effect; exactly 160 words and one `done`.
- Assert `rst_in` asynchronously at cycle 50, release, then `start_in`. Required: all outputs 0 during reset, no stale words after release, new pass starts at index 0.
- Back-to-back passes: `start_in` in the cycle after `done`. Required: accepted, and the second pass matches the first.
